// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter feeding one FIFO write port
// Define FIFO_ARB_PRIO0_EN to favour requester 0 at every arbitration point.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          wfull,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [2:0]                    gnt_id,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [2:0] LAST_IDX  = 3'(NUM_REQ - 1);
  localparam logic [4:0] BURST_MAX = 5'(MAX_BURST);

  state_t     state_q, state_d;
  logic [2:0] owner_q, owner_d;
  logic [2:0] rr_ptr_q, rr_ptr_d;
  logic [2:0] gnt_id_q, gnt_id_d;
  logic [4:0] burst_cnt_q, burst_cnt_d;

  logic [7:0] req_x;
  logic       arb_point;
  logic [2:0] search_base;
  logic       win_found;
  logic [2:0] win_idx;
  logic       grant_en;
  logic [2:0] grant_idx;
  logic [4:0] new_cnt;

  function automatic logic [2:0] next_idx(input logic [2:0] i);
    return (i == LAST_IDX) ? 3'd0 : i + 3'd1;
  endfunction

  assign req_x       = 8'(req);
  // A dropped owner hands off in the same cycle, searching from the slot after it.
  assign arb_point   = (state_q == IDLE) || !req_x[owner_q];
  assign search_base = (state_q == BURST) ? next_idx(owner_q) : rr_ptr_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q     <= IDLE;
      owner_q     <= 3'd0;
      rr_ptr_q    <= 3'd0;
      gnt_id_q    <= 3'd0;
      burst_cnt_q <= 5'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_id_q    <= gnt_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    logic [2:0] scan_idx;
    win_found = 1'b0;
    win_idx   = 3'd0;
    scan_idx  = search_base;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_x[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
      scan_idx = next_idx(scan_idx);
    end
`ifdef FIFO_ARB_PRIO0_EN
    if (req[0]) begin
      win_found = 1'b1;
      win_idx   = 3'd0;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_id_d    = gnt_id_q;
    burst_cnt_d = burst_cnt_q;
    grant_en    = 1'b0;
    grant_idx   = owner_q;
    new_cnt     = 5'd0;
    // A full FIFO freezes everything, including a pending handoff.
    if (!wfull) begin
      if (arb_point) begin
        if (state_q == BURST) rr_ptr_d = next_idx(owner_q);
        if (win_found) begin
          grant_en  = 1'b1;
          grant_idx = win_idx;
        end else begin
          state_d     = IDLE;
          burst_cnt_d = 5'd0;
        end
      end else begin
        grant_en  = 1'b1;
        grant_idx = owner_q;
      end
      if (grant_en) begin
        new_cnt  = (arb_point ? 5'd0 : burst_cnt_q) + 5'd1;
        gnt_id_d = grant_idx;
        owner_d  = grant_idx;
        if (new_cnt == BURST_MAX) begin
          state_d     = IDLE;
          burst_cnt_d = 5'd0;
          rr_ptr_d    = next_idx(grant_idx);
        end else begin
          state_d     = BURST;
          burst_cnt_d = new_cnt;
        end
      end
    end
  end

  always_comb begin
    gnt   = '0;
    wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wrst_n && grant_en && (grant_idx == 3'(i))) begin
        gnt[i] = 1'b1;
        wdata  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    winc = |gnt;
  end

  assign gnt_id = gnt_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
// Define FIFO_ARB_PRIO0_EN to exercise the requester-0 priority build.
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam int MB = 4;

  logic            wclk = 1'b0;
  logic            wrst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = {8'h44, 8'h33, 8'h22, 8'h11};
  logic            wfull = 1'b0;
  logic [N-1:0]    gnt;
  logic [2:0]      gnt_id;
  logic            winc;
  logic [DW-1:0]   wdata;

  int vectors = 0;
  int miscompares = 0;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .MAX_BURST(MB)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data), .wfull(wfull),
    .gnt(gnt), .gnt_id(gnt_id), .winc(winc), .wdata(wdata)
  );

  always #5 wclk = ~wclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  // Model: owner (-1 = none), words in current burst, pointer, last winner.
  int m_owner = -1;
  int m_cnt = 0;
  int m_ptr = 0;
  int m_id = 0;
  int wait_acc[N];

  always @(negedge wclk) begin
    if (!wrst_n) begin
      m_owner = -1; m_cnt = 0; m_ptr = 0; m_id = 0;
      for (int i = 0; i < N; i++) wait_acc[i] = 0;
      check("reset_gnt", 32'(gnt), 0);
      check("reset_winc", 32'(winc), 0);
      check("reset_wdata", 32'(wdata), 0);
      check("reset_gnt_id", 32'(gnt_id), 0);
    end else begin
      int exp_w;
      int base;
      logic [N-1:0] exp_g;
      logic [DW-1:0] exp_d;
      exp_w = -1;
      if (!wfull) begin
        if (m_owner >= 0 && req[m_owner]) exp_w = m_owner;
        else begin
          base = (m_owner < 0) ? m_ptr : (m_owner + 1) % N;
          for (int k = 0; k < N; k++)
            if (exp_w < 0 && req[(base + k) % N]) exp_w = (base + k) % N;
`ifdef FIFO_ARB_PRIO0_EN
          if (req[0]) exp_w = 0;
`endif
          if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
          m_owner = exp_w;
          m_cnt = 0;
        end
      end
      exp_g = (exp_w >= 0) ? N'(1) << exp_w : '0;
      exp_d = (exp_w >= 0) ? req_data[exp_w*DW +: DW] : '0;
      check("model_gnt", 32'(gnt), 32'(exp_g));
      check("model_winc", 32'(winc), 32'(exp_w >= 0));
      check("model_wdata", 32'(wdata), 32'(exp_d));
      check("model_gnt_id", 32'(gnt_id), 32'(m_id));
      check("onehot0", 32'($countones(gnt) <= 1), 1);
      check("no_winc_when_full", 32'(winc && wfull), 0);
      if (exp_w >= 0) begin
        m_cnt++;
        m_id = exp_w;
        if (m_cnt == MB) begin
          m_ptr = (exp_w + 1) % N;
          m_owner = -1;
          m_cnt = 0;
        end
      end
`ifndef FIFO_ARB_PRIO0_EN
      for (int i = 0; i < N; i++) begin
        if (!req[i] || gnt[i]) wait_acc[i] = 0;
        else if (winc) wait_acc[i]++;
        check("fairness", 32'(wait_acc[i] <= N * MB), 1);
      end
`endif
    end
  end

  task automatic cyc(input logic [N-1:0] r, input logic wf, output int g);
    req = r;
    wfull = wf;
    #3;
    g = idx_of(gnt);
    @(posedge wclk);
    #1;
  endtask

  initial begin
    int g;
    int words;
    repeat (3) @(posedge wclk);
    #1 wrst_n = 1'b1;

    for (int k = 0; k < 16; k++) begin
      cyc(4'b1111, 1'b0, g);
`ifndef FIFO_ARB_PRIO0_EN
      check("rr_order", 32'(g), 32'(k / 4));
`else
      check("prio_order", 32'(g), 0);
`endif
    end
`ifdef FIFO_ARB_PRIO0_EN
    // Move the pointer forward so later directed cases start from slot 0 as in the default build.
    cyc(4'b1000, 1'b0, g);
`endif
    cyc(4'b0000, 1'b0, g);

    req_data[2*DW +: DW] = 8'hA7;
    words = 0;
    cyc(4'b0100, 1'b0, g); if (g == 2 && wdata === 8'hA7) words++;
    if (g == 2) words = words;
    cyc(4'b0100, 1'b1, g); check("full_no_grant_c2", 32'(g), 32'(-1));
    cyc(4'b0100, 1'b1, g); check("full_no_grant_c3", 32'(g), 32'(-1));
    for (int k = 0; k < 3; k++) begin
      req = 4'b0100; wfull = 1'b0; #3;
      if (idx_of(gnt) == 2 && wdata === 8'hA7) words++;
      @(posedge wclk); #1;
    end
    check("full_total_words", 32'(words), 4);
    cyc(4'b0000, 1'b0, g);

    cyc(4'b0010, 1'b0, g); check("owner1_first", 32'(g), 1);
    cyc(4'b0010, 1'b0, g); check("owner1_second", 32'(g), 1);
    cyc(4'b1000, 1'b0, g); check("handoff_to_3", 32'(g), 3);
    check("handoff_gnt_id", 32'(gnt_id), 3);
    cyc(4'b0000, 1'b0, g);

    cyc(4'b0100, 1'b0, g); check("pre_reset_burst", 32'(g), 2);
    cyc(4'b0100, 1'b0, g);
    req = 4'b0110;
    #1 check("pre_reset_winc", 32'(winc), 1);
    wrst_n = 1'b0;
    #1;
    check("async_rst_winc", 32'(winc), 0);
    check("async_rst_gnt", 32'(gnt), 0);
    check("async_rst_wdata", 32'(wdata), 0);
    @(posedge wclk); #1;
    @(posedge wclk); #1 wrst_n = 1'b1;
    cyc(4'b1111, 1'b0, g); check("after_reset_req0", 32'(g), 0);
    cyc(4'b0000, 1'b0, g);

`ifdef FIFO_ARB_PRIO0_EN
    wrst_n = 1'b0;
    @(posedge wclk); #1 wrst_n = 1'b1;
    cyc(4'b1110, 1'b0, g); check("prio_burst1_w1", 32'(g), 1);
    for (int k = 0; k < 3; k++) begin
      cyc(4'b1111, 1'b0, g); check("prio_no_preempt", 32'(g), 1);
    end
    cyc(4'b1111, 1'b0, g); check("prio_req0_next", 32'(g), 0);
    cyc(4'b0000, 1'b0, g);
`endif

    for (int k = 0; k < 2000; k++) begin
      req_data = (N*DW)'($urandom);
      cyc(N'($urandom), ($urandom_range(0, 3) == 0), g);
    end

    repeat (2) @(posedge wclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
